// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array result drain.
package systolic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_CPL,
    ST_SETTLE,
    ST_SELECT,
    ST_CAPTURE,
    ST_OUTPUT,
    ST_DONE
  } drain_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/drain_index_gen.sv
// Walk position over the NxN PE grid: inner index steps by LANES, outer by 1.
module drain_index_gen
  import systolic_pkg::*;
#(
  parameter int N     = 32,
  parameter int LANES = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                col_major_i,
  input  logic                advance_i,
  output logic [idx_w(N)-1:0] row_o,
  output logic [idx_w(N)-1:0] col_o,
  output logic                last_o
);

  localparam int IW = idx_w(N);
  localparam logic [IW-1:0] INNER_LAST = IW'(N - LANES);
  localparam logic [IW-1:0] OUTER_LAST = IW'(N - 1);

  logic          mode_q, mode_d;
  logic [IW-1:0] inner_q, inner_d;
  logic [IW-1:0] outer_q, outer_d;

  always_comb begin
    mode_d  = mode_q;
    inner_d = inner_q;
    outer_d = outer_q;
    if (clear_i) begin
      mode_d  = col_major_i;
      inner_d = '0;
      outer_d = '0;
    end else if (advance_i) begin
      if (inner_q == INNER_LAST) begin
        inner_d = '0;
        outer_d = outer_q + IW'(1);
      end else begin
        inner_d = inner_q + IW'(LANES);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mode_q  <= 1'b0;
      inner_q <= '0;
      outer_q <= '0;
    end else begin
      mode_q  <= mode_d;
      inner_q <= inner_d;
      outer_q <= outer_d;
    end
  end

  // Column-major walks down a column first, so the row is the inner index.
  assign row_o  = mode_q ? inner_q : outer_q;
  assign col_o  = mode_q ? outer_q : inner_q;
  assign last_o = (outer_q == OUTER_LAST) && (inner_q == INNER_LAST);

endmodule

// File: rtl/systolic_result_drain.sv
// Reads every PE accumulator after matrix-multiply-complete and streams the
// results out over valid/ready, LANES results per beat, with coordinates.
module systolic_result_drain
  import systolic_pkg::*;
#(
  parameter int N              = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LANES          = 1,
  parameter int SETTLE_CYCLES  = 10,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        abort_i,
  input  logic                        col_major_i,
  input  logic                        mult_complete_i,
  output logic [idx_w(N)-1:0]         sel_row_o,
  output logic [idx_w(N)-1:0]         sel_col_o,
  output logic [LANES-1:0]            sel_o,
  input  logic [LANES-1:0]            acc_valid_i,
  input  logic [LANES*DATA_WIDTH-1:0] acc_data_i,
  output logic                        m_valid_o,
  input  logic                        m_ready_i,
  output logic [LANES*DATA_WIDTH-1:0] m_data_o,
  output logic [idx_w(N)-1:0]         m_row_o,
  output logic [idx_w(N)-1:0]         m_col_o,
  output logic                        m_last_o,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        timeout_err_o
);

  localparam int IW      = idx_w(N);
  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = idx_w(CNT_MAX + 1);

  if (N % LANES != 0) begin : g_lane_check
    $error("systolic_result_drain: LANES must divide N");
  end

  drain_state_e                state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [LANES-1:0]            sel_q, sel_d;
  logic [LANES*DATA_WIDTH-1:0] cap_q, cap_d;
  logic                        m_valid_q, m_valid_d;
  logic                        done_q, done_d;
  logic                        terr_q, terr_d;
  logic                        enter_select;
  logic                        idx_clear, idx_advance, idx_last;
  logic [IW-1:0]               idx_row, idx_col;
  logic [LANES-1:0]            lane_hit;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_hit[gi] = sel_q[gi] & acc_valid_i[gi];
  end

  drain_index_gen #(.N(N), .LANES(LANES)) u_index (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (idx_clear),
    .col_major_i (col_major_i),
    .advance_i   (idx_advance),
    .row_o       (idx_row),
    .col_o       (idx_col),
    .last_o      (idx_last)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sel_d        = sel_q;
    cap_d        = cap_q;
    m_valid_d    = m_valid_q;
    done_d       = 1'b0;
    terr_d       = terr_q;
    enter_select = 1'b0;
    idx_clear    = 1'b0;
    idx_advance  = 1'b0;
    if (abort_i) begin
      state_d   = ST_IDLE;
      sel_d     = '0;
      m_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start_i) begin
          state_d   = ST_WAIT_CPL;
          terr_d    = 1'b0;
          idx_clear = 1'b1;
        end
        ST_WAIT_CPL: if (mult_complete_i) begin
          if (SETTLE_CYCLES == 0) enter_select = 1'b1;
          else begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end
        end
        ST_SETTLE: begin
          if (cnt_q == CW'(SETTLE_CYCLES - 1)) enter_select = 1'b1;
          else cnt_d = cnt_q + CW'(1);
        end
        ST_SELECT: begin
          state_d = ST_CAPTURE;
          cnt_d   = '0;
        end
        ST_CAPTURE: begin
          // Each lane keeps only its first answer; its strobe drops once it has one.
          sel_d = sel_q & ~lane_hit;
          for (int k = 0; k < LANES; k++) begin
            if (lane_hit[k]) cap_d[k*DATA_WIDTH +: DATA_WIDTH] = acc_data_i[k*DATA_WIDTH +: DATA_WIDTH];
          end
          if (sel_d == '0) begin
            state_d   = ST_OUTPUT;
            m_valid_d = 1'b1;
          end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d   = ST_OUTPUT;
            sel_d     = '0;
            m_valid_d = 1'b1;
            terr_d    = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_OUTPUT: if (m_ready_i) begin
          m_valid_d = 1'b0;
          if (idx_last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            idx_advance  = 1'b1;
            enter_select = 1'b1;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      // Lanes that never answer before the timeout report zero.
      if (enter_select) begin
        state_d = ST_SELECT;
        sel_d   = '1;
        cap_d   = '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      cap_q     <= '0;
      m_valid_q <= 1'b0;
      done_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      cap_q     <= cap_d;
      m_valid_q <= m_valid_d;
      done_q    <= done_d;
      terr_q    <= terr_d;
    end
  end

  assign sel_row_o     = idx_row;
  assign sel_col_o     = idx_col;
  assign sel_o         = sel_q;
  assign m_valid_o     = m_valid_q;
  assign m_data_o      = cap_q;
  assign m_row_o       = idx_row;
  assign m_col_o       = idx_col;
  assign m_last_o      = idx_last & m_valid_q;
  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = done_q;
  assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench: two drains (LANES=2 and LANES=4) on a 4x4 grid with a simple PE model.
module tb_systolic_result_drain;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LA = 2;
  localparam int LB = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pe_val(input int r, input int c);
    return DW'(32'hA000 + r * 16 + c);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- DUT A: LANES=2 ----------------
  logic a_start = 1'b0, a_abort = 1'b0, a_colm = 1'b0, a_cpl = 1'b0, a_ready = 1'b1;
  logic a_stuck = 1'b0;
  logic [IW-1:0] a_sel_row, a_sel_col, a_m_row, a_m_col;
  logic [LA-1:0] a_sel, a_acc_valid, a_sel_d1;
  logic [LA*DW-1:0] a_acc_data, a_m_data;
  logic a_m_valid, a_m_last, a_busy, a_done, a_terr;

  systolic_result_drain #(.N(N), .DATA_WIDTH(DW), .LANES(LA), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(8)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(a_start), .abort_i(a_abort), .col_major_i(a_colm),
    .mult_complete_i(a_cpl), .sel_row_o(a_sel_row), .sel_col_o(a_sel_col), .sel_o(a_sel),
    .acc_valid_i(a_acc_valid), .acc_data_i(a_acc_data), .m_valid_o(a_m_valid), .m_ready_i(a_ready),
    .m_data_o(a_m_data), .m_row_o(a_m_row), .m_col_o(a_m_col), .m_last_o(a_m_last),
    .busy_o(a_busy), .done_o(a_done), .timeout_err_o(a_terr)
  );

  // PEs answer one cycle after their strobe rises; a_stuck mutes lane 1 of PE block (0,0).
  always @(posedge clk or posedge rst) if (rst) a_sel_d1 <= '0; else a_sel_d1 <= a_sel;
  always_comb begin
    a_acc_valid = a_sel & a_sel_d1;
    if (a_stuck && a_sel_row == 0 && a_sel_col == 0) a_acc_valid[1] = 1'b0;
    for (int k = 0; k < LA; k++)
      a_acc_data[k*DW +: DW] = a_colm ? pe_val(int'(a_sel_row) + k, int'(a_sel_col))
                                      : pe_val(int'(a_sel_row), int'(a_sel_col) + k);
  end

  logic [LA*DW-1:0] qa_data[$];
  int qa_row[$], qa_col[$], qa_last[$];
  int a_done_cnt = 0, a_overlap = 0, a_unstable = 0;
  logic a_hold = 1'b0;
  logic [LA*DW-1:0] a_prev_data;
  logic [IW-1:0] a_prev_row, a_prev_col;

  always @(posedge clk) begin
    if (rst) begin
      a_hold = 1'b0;
    end else begin
      if (a_m_valid && a_ready) begin
        qa_data.push_back(a_m_data);
        qa_row.push_back(int'(a_m_row));
        qa_col.push_back(int'(a_m_col));
        qa_last.push_back(int'(a_m_last));
        $display("[TB] A beat row=%0d col=%0d last=%0b data=%h", a_m_row, a_m_col, a_m_last, a_m_data);
      end
      if (a_done) a_done_cnt++;
      if (a_m_valid && a_sel != '0) a_overlap++;
      if (a_hold && (!a_m_valid || a_m_data != a_prev_data || a_m_row != a_prev_row || a_m_col != a_prev_col))
        a_unstable++;
      a_hold      = a_m_valid && !a_ready;
      a_prev_data = a_m_data;
      a_prev_row  = a_m_row;
      a_prev_col  = a_m_col;
    end
  end

  // ---------------- DUT B: LANES=4 ----------------
  logic b_start = 1'b0, b_abort = 1'b0, b_colm = 1'b0, b_cpl = 1'b0, b_ready = 1'b1;
  logic [IW-1:0] b_sel_row, b_sel_col, b_m_row, b_m_col;
  logic [LB-1:0] b_sel, b_acc_valid, b_sel_d1;
  logic [LB*DW-1:0] b_acc_data, b_m_data;
  logic b_m_valid, b_m_last, b_busy, b_done, b_terr;

  systolic_result_drain #(.N(N), .DATA_WIDTH(DW), .LANES(LB), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(8)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .abort_i(b_abort), .col_major_i(b_colm),
    .mult_complete_i(b_cpl), .sel_row_o(b_sel_row), .sel_col_o(b_sel_col), .sel_o(b_sel),
    .acc_valid_i(b_acc_valid), .acc_data_i(b_acc_data), .m_valid_o(b_m_valid), .m_ready_i(b_ready),
    .m_data_o(b_m_data), .m_row_o(b_m_row), .m_col_o(b_m_col), .m_last_o(b_m_last),
    .busy_o(b_busy), .done_o(b_done), .timeout_err_o(b_terr)
  );

  always @(posedge clk or posedge rst) if (rst) b_sel_d1 <= '0; else b_sel_d1 <= b_sel;
  always_comb begin
    b_acc_valid = b_sel & b_sel_d1;
    for (int k = 0; k < LB; k++)
      b_acc_data[k*DW +: DW] = pe_val(int'(b_sel_row), int'(b_sel_col) + k);
  end

  logic [LB*DW-1:0] qb_data[$];
  int qb_row[$], qb_col[$], qb_last[$];
  int b_done_cnt = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (b_m_valid && b_ready) begin
        qb_data.push_back(b_m_data);
        qb_row.push_back(int'(b_m_row));
        qb_col.push_back(int'(b_m_col));
        qb_last.push_back(int'(b_m_last));
        $display("[TB] B beat row=%0d col=%0d last=%0b data=%h", b_m_row, b_m_col, b_m_last, b_m_data);
      end
      if (b_done) b_done_cnt++;
    end
  end

  // ---------------- helpers ----------------
  // what: 0 A done count >= arg, 1 A beats >= arg, 2 A sel nonzero, 3 A m_valid, else B done count >= arg
  task automatic wait_for(input int what, input int arg, output int n);
    bit hit;
    n = 0;
    forever begin
      case (what)
        0:       hit = (a_done_cnt >= arg);
        1:       hit = (qa_data.size() >= arg);
        2:       hit = (a_sel != '0);
        3:       hit = a_m_valid;
        default: hit = (b_done_cnt >= arg);
      endcase
      if (hit || n >= 600) break;
      tick(1);
      n++;
    end
    check($sformatf("wait%0d_%0d", what, arg), hit, 1);
  endtask

  task automatic start_a(input logic cm);
    a_colm  = cm;
    a_start = 1'b1;
    tick(1);
    a_start = 1'b0;
  endtask

  task automatic check_beats_a(input string tag, input int base, input bit cm, input int first);
    for (int i = first; i < 8; i++) begin
      int r = cm ? (i % 2) * 2 : i / 2;
      int c = cm ? i / 2 : (i % 2) * 2;
      logic [LA*DW-1:0] d;
      for (int k = 0; k < LA; k++) d[k*DW +: DW] = cm ? pe_val(r + k, c) : pe_val(r, c + k);
      check($sformatf("%s_b%0d_pos", tag, i), {qa_row[base+i], qa_col[base+i], qa_last[base+i]},
            {r, c, int'(i == 7)});
      check($sformatf("%s_b%0d_data", tag, i), qa_data[base+i], d);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, base, d0, bbase, bd0;
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst_busy", a_busy, 0);
    check("rst_sel", a_sel, 0);
    check("rst_valid", a_m_valid, 0);
    check("rst_data", a_m_data, 0);
    check("rst_terr", a_terr, 0);
    check("rst_done", a_done, 0);
    check("rst_b_busy", b_busy, 0);

    // 1: row-major, settle latency, full walk
    base = qa_data.size(); d0 = a_done_cnt;
    start_a(1'b0);
    tick(2);
    check("t1_wait_busy", a_busy, 1);
    check("t1_wait_sel", a_sel, 0);
    a_cpl = 1'b1;
    tick(1);                       // edge that samples complete
    wait_for(2, 0, n);
    check("t1_sel_lat", n, 2);
    wait_for(0, d0 + 1, n);
    tick(3);
    check("t1_done_cnt", a_done_cnt - d0, 1);
    check("t1_beats", qa_data.size() - base, 8);
    check_beats_a("t1", base, 1'b0, 0);
    check("t1_b0_const", qa_data[base], 64'h0000A001_0000A000);
    check("t1_b7_const", qa_data[base+7], 64'h0000A033_0000A032);
    check("t1_overlap", a_overlap, 0);
    check("t1_idle", a_busy, 0);

    // 2: column-major
    base = qa_data.size(); d0 = a_done_cnt;
    start_a(1'b1);
    wait_for(0, d0 + 1, n);
    check("t2_beats", qa_data.size() - base, 8);
    check("t2_b0_data", qa_data[base], 64'h0000A010_0000A000);
    check("t2_b1_data", qa_data[base+1], 64'h0000A030_0000A020);
    check("t2_b2_pos", {qa_row[base+2], qa_col[base+2]}, {32'd0, 32'd1});
    check_beats_a("t2", base, 1'b1, 0);

    // 3: backpressure on beat 3
    base = qa_data.size(); d0 = a_done_cnt;
    start_a(1'b0);
    wait_for(1, base + 3, n);
    a_ready = 1'b0;
    wait_for(3, 0, n);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_hold%0d_valid", i), a_m_valid, 1);
      check($sformatf("t3_hold%0d_sel", i), a_sel, 0);
      check($sformatf("t3_hold%0d_data", i), a_m_data, 64'h0000A013_0000A012);
      check($sformatf("t3_hold%0d_pos", i), {a_m_row, a_m_col}, 4'b01_10);
      tick(1);
    end
    a_ready = 1'b1;
    wait_for(0, d0 + 1, n);
    check("t3_beats", qa_data.size() - base, 8);
    check_beats_a("t3", base, 1'b0, 0);
    check("t3_unstable", a_unstable, 0);
    check("t3_overlap", a_overlap, 0);

    // 4: lane 1 never answers on beat 0
    base = qa_data.size(); d0 = a_done_cnt;
    a_stuck = 1'b1;
    start_a(1'b0);
    wait_for(2, 0, n);
    tick(4);
    check("t4_sel_mask", a_sel, 2'b10);
    wait_for(3, 0, n);
    check("t4_cap_len", n, 5);
    check("t4_terr_set", a_terr, 1);
    check("t4_b0_out", a_m_data, 64'h00000000_0000A000);
    wait_for(0, d0 + 1, n);
    tick(2);
    check("t4_terr_sticky", a_terr, 1);
    check("t4_beats", qa_data.size() - base, 8);
    check_beats_a("t4", base, 1'b0, 1);
    a_stuck = 1'b0;

    // 5a: abort during capture of beat 4
    base = qa_data.size(); d0 = a_done_cnt;
    start_a(1'b0);
    check("t5_terr_clr", a_terr, 0);
    wait_for(1, base + 4, n);
    wait_for(2, 0, n);
    tick(1);
    a_abort = 1'b1;
    tick(1);
    a_abort = 1'b0;
    check("t5_abort_busy", a_busy, 0);
    check("t5_abort_sel", a_sel, 0);
    check("t5_abort_valid", a_m_valid, 0);
    tick(3);
    check("t5_abort_nodone", a_done_cnt - d0, 0);
    check("t5_abort_beats", qa_data.size() - base, 4);

    // 5b: reset while a beat is presented
    base = qa_data.size();
    start_a(1'b0);
    wait_for(1, base + 3, n);
    a_ready = 1'b0;
    wait_for(3, 0, n);
    check("t5_pre_pos", {a_m_row, a_m_col}, 4'b01_10);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", a_m_valid, 0);
    check("t5_rst_data", a_m_data, 0);
    check("t5_rst_pos", {a_m_row, a_m_col}, 0);
    check("t5_rst_busy", a_busy, 0);
    check("t5_rst_sel", a_sel, 0);
    tick(1);
    rst = 1'b0;
    a_ready = 1'b1;
    tick(1);

    // 6: LANES=4, complete already high, second start while busy
    bbase = qb_data.size(); bd0 = b_done_cnt;
    b_cpl = 1'b1;
    tick(1);
    b_colm = 1'b0; b_start = 1'b1;
    tick(1);
    b_start = 1'b0;
    tick(1);
    check("t6_busy", b_busy, 1);
    b_colm = 1'b1; b_start = 1'b1;
    tick(1);
    b_start = 1'b0;
    wait_for(4, bd0 + 1, n);
    tick(3);
    check("t6_done_cnt", b_done_cnt - bd0, 1);
    check("t6_beats", qb_data.size() - bbase, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t6_b%0d_pos", i), {qb_row[bbase+i], qb_col[bbase+i], qb_last[bbase+i]},
            {i, 32'd0, int'(i == 3)});
    check("t6_b1_data", qb_data[bbase+1], 128'h0000A013_0000A012_0000A011_0000A010);
    check("t6_b3_data", qb_data[bbase+3], 128'h0000A033_0000A032_0000A031_0000A030);
    check("t6_idle", b_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
